// File: rtl/sd_regbank_bus_if.sv
// Host access port of the SD register bank: req/ack handshake with byte-lane write enables.
interface sd_regbank_bus_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  localparam int BPL = DATA_W / 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BPL-1:0]    be;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/sd_regbank_bus.sv
// SD controller register bank: byte-lane bus access, interrupt status/masking and command launch.
module sd_regbank_bus #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 7,
  parameter logic [11:0] RST_BLKSIZE = 12'd511,
  parameter logic [31:0] VOLTAGE     = 32'd3300,
  parameter logic [15:0] CAPA        = 16'h0000,
  localparam int BPL       = DATA_W / 8,
  localparam int CMD_W     = 14,
  localparam int TOUT_W    = 24,
  localparam int BLKSIZE_W = 12,
  localparam int CTRL_W    = 16,
  localparam int ICMD_W    = 5,
  localparam int IDATA_W   = 3,
  localparam int CLKDIV_W  = 8,
  localparam int BLKCNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sd_regbank_bus_if.slave      bus,
  input  logic                 cmd_busy,
  input  logic [ICMD_W-1:0]    cmd_int_set,
  input  logic [IDATA_W-1:0]   data_int_set,
  input  logic [31:0]          response_0_reg,
  input  logic [31:0]          response_1_reg,
  input  logic [31:0]          response_2_reg,
  input  logic [31:0]          response_3_reg,
  output logic [31:0]          argument_reg,
  output logic [CMD_W-1:0]     command_reg,
  output logic                 software_reset_reg,
  output logic [TOUT_W-1:0]    cmd_timeout_reg,
  output logic [TOUT_W-1:0]    data_timeout_reg,
  output logic [BLKSIZE_W-1:0] block_size_reg,
  output logic [CTRL_W-1:0]    controll_setting_reg,
  output logic [ICMD_W-1:0]    cmd_int_enable_reg,
  output logic [CLKDIV_W-1:0]  clock_divider_reg,
  output logic [IDATA_W-1:0]   data_int_enable_reg,
  output logic [BLKCNT_W-1:0]  block_count_reg,
  output logic [31:0]          dma_addr_reg,
  output logic                 cmd_start,
  output logic                 irq
);
  localparam logic [31:0] A_ARG    = 32'h00, A_CMD    = 32'h04, A_RESP0  = 32'h08,
                          A_RESP1  = 32'h0C, A_RESP2  = 32'h10, A_RESP3  = 32'h14,
                          A_DTOUT  = 32'h18, A_CTRL   = 32'h1C, A_CTOUT  = 32'h20,
                          A_CLKDIV = 32'h24, A_SWRST  = 32'h28, A_VOLT   = 32'h2C,
                          A_CAPA   = 32'h30, A_CISR   = 32'h34, A_CISER  = 32'h38,
                          A_DISR   = 32'h3C, A_DISER  = 32'h40, A_BLKSZ  = 32'h44,
                          A_BLKCNT = 32'h48, A_DMA    = 32'h60;

  logic                 ack_q, ack_d, start_q, start_d, irq_q, irq_d, berr_q, berr_d;
  logic                 acc, wr;
  logic [1:0]           lane_base;
  logic [31:0]          woff, base32, wdat32, wmask32, rd_word, merged;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [31:0]          arg_q, arg_d, dma_q, dma_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic                 swrst_q, swrst_d;
  logic [TOUT_W-1:0]    ctout_q, ctout_d, dtout_q, dtout_d;
  logic [BLKSIZE_W-1:0] blksz_q, blksz_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [ICMD_W-1:0]    cie_q, cie_d, cst_q, cst_d;
  logic [IDATA_W-1:0]   die_q, die_d, dst_q, dst_d;
  logic [CLKDIV_W-1:0]  cdiv_q, cdiv_d;
  logic [BLKCNT_W-1:0]  bcnt_q, bcnt_d;

  assign acc       = bus.req & ~ack_q;
  assign wr        = acc & bus.we;
  assign woff      = 32'(bus.addr) & 32'hFFFF_FFFC;
  assign lane_base = bus.addr[1:0] & 2'(~(BPL - 1));
  assign base32    = {30'd0, lane_base};

  always_comb begin
    wdat32  = '0;
    wmask32 = '0;
    rdata_d = rdata_q;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned i = 0; i < BPL; i++) begin
        if (base32 + i == b) begin
          wdat32[8*b +: 8]  = bus.wdata[8*i +: 8];
          wmask32[8*b +: 8] = {8{bus.be[i]}};
          if (acc && !bus.we) rdata_d[8*i +: 8] = rd_word[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (woff)
      A_ARG:    rd_word = arg_q;
      A_CMD:    rd_word = 32'(cmd_q);
      A_RESP0:  rd_word = response_0_reg;
      A_RESP1:  rd_word = response_1_reg;
      A_RESP2:  rd_word = response_2_reg;
      A_RESP3:  rd_word = response_3_reg;
      A_DTOUT:  rd_word = 32'(dtout_q);
      A_CTRL:   rd_word = 32'({ctrl_q[CTRL_W-1:2], berr_q, ctrl_q[0]});
      A_CTOUT:  rd_word = 32'(ctout_q);
      A_CLKDIV: rd_word = 32'(cdiv_q);
      A_SWRST:  rd_word = 32'(swrst_q);
      A_VOLT:   rd_word = VOLTAGE;
      A_CAPA:   rd_word = 32'(CAPA);
      A_CISR:   rd_word = 32'(cst_q);
      A_CISER:  rd_word = 32'(cie_q);
      A_DISR:   rd_word = 32'(dst_q);
      A_DISER:  rd_word = 32'(die_q);
      A_BLKSZ:  rd_word = 32'(blksz_q);
      A_BLKCNT: rd_word = 32'(bcnt_q);
      A_DMA:    rd_word = dma_q;
      default:  rd_word = '0;
    endcase
  end

  // Stored registers merge new lanes into the current read-back word, then truncate to width.
  always_comb begin
    merged  = (rd_word & ~wmask32) | (wdat32 & wmask32);
    arg_d   = arg_q;   cmd_d   = cmd_q;   dtout_d = dtout_q; ctrl_d = ctrl_q;
    ctout_d = ctout_q; cdiv_d  = cdiv_q;  swrst_d = swrst_q; cie_d  = cie_q;
    die_d   = die_q;   blksz_d = blksz_q; bcnt_d  = bcnt_q;  dma_d  = dma_q;
    if (wr) begin
      case (woff)
        A_ARG:    if (!cmd_busy) arg_d = merged;
        A_CMD:    if (!cmd_busy) cmd_d = CMD_W'(merged);
        A_DTOUT:  dtout_d = TOUT_W'(merged);
        A_CTRL:   ctrl_d  = {merged[CTRL_W-1:2], 1'b0, merged[0]};
        A_CTOUT:  ctout_d = TOUT_W'(merged);
        A_CLKDIV: cdiv_d  = CLKDIV_W'(merged);
        A_SWRST:  swrst_d = merged[0];
        A_CISER:  cie_d   = ICMD_W'(merged);
        A_DISER:  die_d   = IDATA_W'(merged);
        A_BLKSZ:  blksz_d = BLKSIZE_W'(merged);
        A_BLKCNT: bcnt_d  = BLKCNT_W'(merged);
        A_DMA:    dma_d   = merged;
        default:  ;
      endcase
    end
  end

  // Controller bit 1 is the sticky busy_err flag (W1C); the stored bit stays 0.
  always_comb begin
    ack_d   = acc;
    start_d = wr & ~cmd_busy & (woff == A_ARG) & wmask32[31];
    berr_d  = (wr & cmd_busy & ((woff == A_ARG) | (woff == A_CMD))) |
              (berr_q & ~(wr & (woff == A_CTRL) & wdat32[1] & wmask32[1]));
    cst_d   = cmd_int_set  | (cst_q & ~((wr && woff == A_CISR) ? ICMD_W'(wdat32 & wmask32) : '0));
    dst_d   = data_int_set | (dst_q & ~((wr && woff == A_DISR) ? IDATA_W'(wdat32 & wmask32) : '0));
    irq_d   = (|(cst_q & cie_q)) | (|(dst_q & die_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;  start_q <= 1'b0; irq_q <= 1'b0;  berr_q <= 1'b0; rdata_q <= '0;
      arg_q <= '0;    cmd_q   <= '0;   dtout_q <= '0;  ctrl_q <= '0;   ctout_q <= '0;
      cdiv_q <= '0;   swrst_q <= 1'b0; cie_q <= '0;    die_q <= '0;    blksz_q <= RST_BLKSIZE;
      bcnt_q <= '0;   dma_q   <= '0;   cst_q <= '0;    dst_q <= '0;
    end else begin
      ack_q <= ack_d;   start_q <= start_d; irq_q <= irq_d;   berr_q <= berr_d; rdata_q <= rdata_d;
      arg_q <= arg_d;   cmd_q   <= cmd_d;   dtout_q <= dtout_d; ctrl_q <= ctrl_d; ctout_q <= ctout_d;
      cdiv_q <= cdiv_d; swrst_q <= swrst_d; cie_q <= cie_d;   die_q <= die_d;   blksz_q <= blksz_d;
      bcnt_q <= bcnt_d; dma_q   <= dma_d;   cst_q <= cst_d;   dst_q <= dst_d;
    end
  end

  assign bus.ack              = ack_q;
  assign bus.rdata            = rdata_q;
  assign cmd_start            = start_q;
  assign irq                  = irq_q;
  assign argument_reg         = arg_q;
  assign command_reg          = cmd_q;
  assign software_reset_reg   = swrst_q;
  assign cmd_timeout_reg      = ctout_q;
  assign data_timeout_reg     = dtout_q;
  assign block_size_reg       = blksz_q;
  assign controll_setting_reg = ctrl_q;
  assign cmd_int_enable_reg   = cie_q;
  assign clock_divider_reg    = cdiv_q;
  assign data_int_enable_reg  = die_q;
  assign block_count_reg      = bcnt_q;
  assign dma_addr_reg         = dma_q;
endmodule

// File: tb/tb_sd_regbank_bus.sv
// Self-checking bench for sd_regbank_bus: 8-bit random traffic against a register-map model, 16/32-bit directed cases.
module tb_sd_regbank_bus;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_busy;
  logic [4:0]  cset;
  logic [2:0]  dset;
  logic [31:0] resp [4];

  sd_regbank_bus_if #(.DATA_W(8),  .ADDR_W(7)) b8  ();
  sd_regbank_bus_if #(.DATA_W(16), .ADDR_W(7)) b16 ();
  sd_regbank_bus_if #(.DATA_W(32), .ADDR_W(7)) b32 ();

  logic [31:0] arg8, arg16, arg32, dma8, dma16, dma32;
  logic [13:0] cmdr8, cmdr16, cmdr32;
  logic        swr8, swr16, swr32, st8, st16, st32, irq8, irq16, irq32;
  logic [23:0] cto8, cto16, cto32, dto8, dto16, dto32;
  logic [11:0] bsz8, bsz16, bsz32;
  logic [15:0] ctl8, ctl16, ctl32, bcn8, bcn16, bcn32;
  logic [4:0]  cie8, cie16, cie32;
  logic [7:0]  cdv8, cdv16, cdv32;
  logic [2:0]  die8, die16, die32;

  sd_regbank_bus #(.DATA_W(8)) u8 (
    .clk(clk), .rst(rst), .bus(b8), .cmd_busy(cmd_busy), .cmd_int_set(cset), .data_int_set(dset),
    .response_0_reg(resp[0]), .response_1_reg(resp[1]), .response_2_reg(resp[2]), .response_3_reg(resp[3]),
    .argument_reg(arg8), .command_reg(cmdr8), .software_reset_reg(swr8), .cmd_timeout_reg(cto8),
    .data_timeout_reg(dto8), .block_size_reg(bsz8), .controll_setting_reg(ctl8), .cmd_int_enable_reg(cie8),
    .clock_divider_reg(cdv8), .data_int_enable_reg(die8), .block_count_reg(bcn8), .dma_addr_reg(dma8),
    .cmd_start(st8), .irq(irq8));

  sd_regbank_bus #(.DATA_W(16)) u16 (
    .clk(clk), .rst(rst), .bus(b16), .cmd_busy(cmd_busy), .cmd_int_set(5'd0), .data_int_set(3'd0),
    .response_0_reg(resp[0]), .response_1_reg(resp[1]), .response_2_reg(resp[2]), .response_3_reg(resp[3]),
    .argument_reg(arg16), .command_reg(cmdr16), .software_reset_reg(swr16), .cmd_timeout_reg(cto16),
    .data_timeout_reg(dto16), .block_size_reg(bsz16), .controll_setting_reg(ctl16), .cmd_int_enable_reg(cie16),
    .clock_divider_reg(cdv16), .data_int_enable_reg(die16), .block_count_reg(bcn16), .dma_addr_reg(dma16),
    .cmd_start(st16), .irq(irq16));

  sd_regbank_bus #(.DATA_W(32)) u32 (
    .clk(clk), .rst(rst), .bus(b32), .cmd_busy(cmd_busy), .cmd_int_set(5'd0), .data_int_set(3'd0),
    .response_0_reg(resp[0]), .response_1_reg(resp[1]), .response_2_reg(resp[2]), .response_3_reg(resp[3]),
    .argument_reg(arg32), .command_reg(cmdr32), .software_reset_reg(swr32), .cmd_timeout_reg(cto32),
    .data_timeout_reg(dto32), .block_size_reg(bsz32), .controll_setting_reg(ctl32), .cmd_int_enable_reg(cie32),
    .clock_divider_reg(cdv32), .data_int_enable_reg(die32), .block_count_reg(bcn32), .dma_addr_reg(dma32),
    .cmd_start(st32), .irq(irq32));

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Register-map model: one 32-bit word per offset, masked to the implemented bits.
  logic [31:0] m_reg [32];
  logic [4:0]  m_cst;
  logic [2:0]  m_dst;
  logic        m_berr;

  function automatic logic [31:0] wmask(input logic [7:0] off);
    case (off)
      8'h00, 8'h60: return 32'hFFFF_FFFF;
      8'h04:        return 32'h0000_3FFF;
      8'h18, 8'h20: return 32'h00FF_FFFF;
      8'h1C:        return 32'h0000_FFFD;
      8'h24:        return 32'h0000_00FF;
      8'h28:        return 32'h0000_0001;
      8'h38:        return 32'h0000_001F;
      8'h40:        return 32'h0000_0007;
      8'h44:        return 32'h0000_0FFF;
      8'h48:        return 32'h0000_FFFF;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] off);
    case (off)
      8'h08:   return resp[0];
      8'h0C:   return resp[1];
      8'h10:   return resp[2];
      8'h14:   return resp[3];
      8'h1C:   return (m_reg[7] & 32'hFFFD) | (m_berr ? 32'h2 : 32'h0);
      8'h2C:   return 32'd3300;
      8'h30:   return 32'h0;
      8'h34:   return {27'd0, m_cst};
      8'h3C:   return {29'd0, m_dst};
      default: return m_reg[off[6:2]] & wmask(off);
    endcase
  endfunction

  function automatic logic mirq();
    return ((m_cst & m_reg[14][4:0]) != 0) || ((m_dst & m_reg[16][2:0]) != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[17] = 32'd511;
    m_cst = '0; m_dst = '0; m_berr = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [31:0] bm,
                             input logic busy, output logic start);
    start = (off == 8'h00) && !busy && bm[31];
    if ((off == 8'h00 || off == 8'h04) && busy) m_berr = 1'b1;
    else begin
      m_reg[off[6:2]] = ((m_reg[off[6:2]] & ~bm) | (d & bm)) & wmask(off);
      if (off == 8'h1C && bm[1] && d[1]) m_berr = 1'b0;
      if (off == 8'h34) m_cst = m_cst & ~(d[4:0] & bm[4:0]);
      if (off == 8'h3C) m_dst = m_dst & ~(d[2:0] & bm[2:0]);
    end
  endtask

  // One 8-bit access started at a falling edge; ends two cycles later at a falling edge.
  task automatic acc8(input logic w, input logic [7:0] off, input int unsigned lane, input logic [7:0] wd,
                      input logic be, input logic busy, input logic [4:0] cs, input logic [2:0] ds,
                      output logic [7:0] rd);
    logic [31:0] d32, bm, rexp;
    logic        st_exp, irq_prev;
    d32      = 32'(wd) << (8 * lane);
    bm       = be ? (32'hFF << (8 * lane)) : 32'h0;
    rexp     = (mread(off) >> (8 * lane)) & 32'hFF;
    irq_prev = mirq();
    st_exp   = 1'b0;
    b8.req = 1'b1; b8.we = w; b8.addr = 7'(off) + 7'(lane); b8.wdata = wd; b8.be = be;
    cmd_busy = busy; cset = cs; dset = ds;
    @(posedge clk);
    if (w) model_write(off, d32, bm, busy, st_exp);
    m_cst = m_cst | cs;
    m_dst = m_dst | ds;
    @(negedge clk);
    rd = b8.rdata;
    check_eq("ack8_hi", 32'(b8.ack), 32'd1);
    check_eq("cmd_start8", 32'(st8), 32'(st_exp));
    check_eq("irq8_prev", 32'(irq8), 32'(irq_prev));
    if (!w) check_eq("rdata8", 32'(b8.rdata), rexp);
    b8.req = 1'b0; cmd_busy = 1'b0; cset = '0; dset = '0;
    @(posedge clk);
    @(negedge clk);
    check_eq("ack8_lo", 32'(b8.ack), 32'd0);
    check_eq("cmd_start8_lo", 32'(st8), 32'd0);
    check_eq("irq8_now", 32'(irq8), 32'(mirq()));
  endtask

  task automatic check_regs8();
    check_eq("arg8", arg8, m_reg[0]);
    check_eq("cmd8", 32'(cmdr8), m_reg[1]);
    check_eq("dto8", 32'(dto8), m_reg[6]);
    check_eq("ctl8", 32'(ctl8), m_reg[7]);
    check_eq("cto8", 32'(cto8), m_reg[8]);
    check_eq("cdv8", 32'(cdv8), m_reg[9]);
    check_eq("swr8", 32'(swr8), m_reg[10]);
    check_eq("cie8", 32'(cie8), m_reg[14]);
    check_eq("die8", 32'(die8), m_reg[16]);
    check_eq("bsz8", 32'(bsz8), m_reg[17]);
    check_eq("bcn8", 32'(bcn8), m_reg[18]);
    check_eq("dma8", dma8, m_reg[24]);
  endtask

  task automatic acc32(input logic w, input logic [6:0] a, input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd);
    b32.req = 1'b1; b32.we = w; b32.addr = a; b32.wdata = wd; b32.be = be;
    @(posedge clk);
    @(negedge clk);
    check_eq("ack32_hi", 32'(b32.ack), 32'd1);
    check_eq("cmd_start32", 32'(st32), 32'd0);
    rd = b32.rdata;
    b32.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("ack32_lo", 32'(b32.ack), 32'd0);
  endtask

  task automatic acc16(input logic w, input logic [6:0] a, input logic [15:0] wd, input logic [1:0] be,
                       output logic [15:0] rd);
    b16.req = 1'b1; b16.we = w; b16.addr = a; b16.wdata = wd; b16.be = be;
    @(posedge clk);
    @(negedge clk);
    check_eq("ack16_hi", 32'(b16.ack), 32'd1);
    rd = b16.rdata;
    b16.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] offs [22] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28,
                            8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h60, 8'h4C, 8'h7C};
  logic [7:0] argb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    logic [7:0]  r8;
    logic [15:0] r16;
    logic [31:0] r32;
    int unsigned nack;
    rst = 1'b1; cmd_busy = 1'b0; cset = '0; dset = '0;
    resp[0] = $urandom; resp[1] = 32'h1234_5678; resp[2] = $urandom; resp[3] = $urandom;
    b8.req = 0;  b8.we = 0;  b8.addr = '0;  b8.wdata = '0;  b8.be = '0;
    b16.req = 0; b16.we = 0; b16.addr = '0; b16.wdata = '0; b16.be = '0;
    b32.req = 0; b32.we = 0; b32.addr = '0; b32.wdata = '0; b32.be = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_ack", 32'(b8.ack), 32'd0);
    check_eq("rst_rdata", 32'(b8.rdata), 32'd0);
    check_eq("rst_start", 32'(st8), 32'd0);
    check_eq("rst_irq", 32'(irq8), 32'd0);
    check_eq("rst_blksize", 32'(bsz8), 32'd511);
    check_eq("rst_arg32", arg32, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) acc8(1'b1, 8'h00, i, argb[i], 1'b1, 1'b0, '0, '0, r8);
    check_eq("arg_bytes", arg8, 32'h4433_2211);

    for (int i = 0; i < 4; i++) acc8(1'b1, 8'h00, i, 8'hEE, 1'b1, 1'b1, '0, '0, r8);
    check_eq("arg_busy_kept", arg8, 32'h4433_2211);
    acc8(1'b0, 8'h1C, 0, 8'h00, 1'b0, 1'b0, '0, '0, r8);
    check_eq("busy_err_set", 32'(r8[1]), 32'd1);
    acc8(1'b1, 8'h1C, 0, 8'h02, 1'b1, 1'b0, '0, '0, r8);
    acc8(1'b0, 8'h1C, 0, 8'h00, 1'b0, 1'b0, '0, '0, r8);
    check_eq("busy_err_clr", 32'(r8[1]), 32'd0);

    acc8(1'b1, 8'h38, 0, 8'h01, 1'b1, 1'b0, '0, '0, r8);
    acc8(1'b0, 8'h2C, 0, 8'h00, 1'b0, 1'b0, 5'h01, '0, r8);
    check_eq("irq_after_pulse", 32'(irq8), 32'd1);
    acc8(1'b1, 8'h34, 0, 8'h01, 1'b1, 1'b0, 5'h01, '0, r8);
    check_eq("irq_set_wins", 32'(irq8), 32'd1);
    acc8(1'b0, 8'h34, 0, 8'h00, 1'b0, 1'b0, '0, '0, r8);
    check_eq("isr_set_wins", 32'(r8), 32'h01);
    acc8(1'b1, 8'h34, 0, 8'h01, 1'b1, 1'b0, '0, '0, r8);
    check_eq("irq_cleared", 32'(irq8), 32'd0);

    acc32(1'b1, 7'h00, 32'hAABB_CCDD, 4'b0011, r32);
    check_eq("arg32_partial", arg32, 32'h0000_CCDD);
    acc32(1'b0, 7'h00, 32'h0, 4'b0000, r32);
    check_eq("rd32_arg", r32, 32'h0000_CCDD);

    b16.req = 1'b1; b16.we = 1'b0; b16.addr = 7'h0E; b16.be = 2'b00;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (b16.ack) nack++;
      if (i == 0) check_eq("rd16_resp1_hi", 32'(b16.rdata), 32'h1234);
    end
    b16.req = 1'b0;
    check_eq("acks_in_6", nack, 32'd3);
    @(posedge clk);
    @(negedge clk);
    acc16(1'b1, 7'h44, 16'hBEEF, 2'b11, r16);
    acc16(1'b1, 7'h46, 16'hFFFF, 2'b11, r16);
    check_eq("bsz16_trunc", 32'(bsz16), 32'h0EEF);
    acc16(1'b0, 7'h44, 16'h0, 2'b11, r16);
    check_eq("rd16_bsz", 32'(r16), 32'h0EEF);

    for (int n = 0; n < 200; n++) begin
      acc8(1'($urandom), offs[$urandom_range(0, 21)], $urandom_range(0, 3), 8'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
           ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0, r8);
      if (n % 20 == 19) check_regs8();
    end

    b8.req = 1'b1; b8.we = 1'b1; b8.addr = 7'h44; b8.wdata = 8'h22; b8.be = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    b8.req = 1'b0;
    @(negedge clk);
    check_eq("midrst_ack", 32'(b8.ack), 32'd0);
    check_eq("midrst_blksize", 32'(bsz8), 32'd511);
    check_eq("midrst_arg", arg8, 32'd0);
    check_eq("midrst_start", 32'(st8), 32'd0);
    check_eq("midrst_irq", 32'(irq8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_regbank_bus.md
Name: sd_regbank_bus

Overview:
- Parametrised single-clock register bank for the SD controller.
- Generalises the byte-wide register file in three ways:
  - bus data width of 8, 16 or 32 bits, with byte-lane enables;
  - a req/ack access handshake with registered read data;
  - interrupt status, masking and the command-start pulse are held inside the block.
- Sits between the host bus adapter and the command/data master FSMs.
- Register offsets are the existing `sd_defines.h` address macros.

Parameters:
- DATA_W, 8: bus data width. Legal values are 8, 16 and 32. BPL = DATA_W/8 byte lanes.
- ADDR_W, 7: byte address width.
- RST_BLKSIZE, `RESET_BLOCK_SIZE: reset value of the block size register.
- VOLTAGE, `SUPPLY_VOLTAGE_mV: constant returned at `voltage`.
- CAPA, 16'h0000: constant returned at `capa`.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- be  in  BPL  byte-lane enables.
- ack  out  1  access complete.
- rdata  out  DATA_W  registered read data.
- cmd_busy  in  1  the command FSM is executing.
- cmd_int_set  in  `INT_CMD_SIZE  one-cycle event pulses from the command FSM.
- data_int_set  in  `INT_DATA_SIZE  one-cycle event pulses from the data FSM.
- argument_reg, command_reg, software_reset_reg, cmd_timeout_reg, data_timeout_reg, block_size_reg, controll_setting_reg, cmd_int_enable_reg, clock_divider_reg, data_int_enable_reg, block_count_reg, dma_addr_reg  out  macro widths  stored register values.
- response_0..3_reg  in  32  response words, read-only.
- cmd_start  out  1  one-cycle command launch pulse.
- irq  out  1  masked interrupt.

Behaviour:
- Reset:
  - every stored register is 0, except block_size_reg = RST_BLKSIZE;
  - ack = 0, rdata = 0, cmd_start = 0, irq = 0;
  - status registers and busy_err are 0.
- Addressing:
  - word = {addr[ADDR_W-1:2], 2'b00};
  - lane base = addr[1:0] rounded down to a multiple of BPL;
  - lane i maps to byte (base+i) of the 32-bit word;
  - bits of a register above its width are ignored on write and read back as 0.
- Handshake:
  - an access is accepted on the edge where req=1 and ack=0;
  - ack=1 on the following cycle, then ack returns to 0;
  - req held high therefore gives one access every 2 cycles;
  - addr, we, wdata and be are sampled only at acceptance.
- Writes:
  - the register updates at the acceptance edge, only in lanes with be=1;
  - a write to a read-only or unmapped offset has no effect but is still acked.
- Reads:
  - rdata is loaded at the acceptance edge with the selected lanes, irrespective of be;
  - rdata is valid while ack=1 and holds its value until the next read;
  - unmapped offsets read 0.
- Command launch:
  - a write accepted at `argument` whose enabled lanes include byte 3, with cmd_busy=0, pulses cmd_start for exactly the cycle in which ack=1.
  - If cmd_busy=1 at acceptance, writes to `argument` and `command` are discarded, cmd_start stays 0, and busy_err is set sticky.
- busy_err:
  - read as bit 1 of `controller`;
  - writing 1 to bit 1 clears it;
  - set wins over a same-cycle clear.
- Interrupt status (`cmd_isr`, `data_isr`):
  - a bit sets on its *_int_set pulse;
  - writing 1 to a bit clears it (W1C), and writing 0 has no effect;
  - a set pulse on the same edge as a W1C clear leaves the bit at 1.
- irq:
  - registered: irq <= |(cmd_status & cmd_int_enable_reg) | |(data_status & data_int_enable_reg);
  - reflects a status change one cycle later.
- Asynchronous reset mid-access: the pending ack is dropped, no write commits and no cmd_start is issued.

Test Plan:
- DATA_W=8; write argument bytes 0..3 = 11,22,33,44 -> argument_reg = 32'h44332211; cmd_start pulses once, in the ack cycle of the byte-3 write only.
- DATA_W=32; write 0xAABBCCDD to `argument` with be=4'b0011, then read it back -> value 0x0000CCDD; ack arrives 1 cycle after req; cmd_start stays 0.
- cmd_busy=1; write `argument` with be=4'hF -> argument_reg unchanged, no cmd_start, controller bit 1 reads 1; a W1C write of 2 clears it.
- cmd_int_set[0] pulses with cmd_int_enable_reg=1 -> irq=1 one cycle later; W1C write of 1 to `cmd_isr` on the same edge as a new set pulse -> bit stays 1, irq stays 1.
- DATA_W=16; read `resp1` with addr offset 2 and response_1_reg = 32'h12345678 -> rdata = 16'h1234; req held high for 6 cycles -> exactly 3 acks.
- Assert rst in the cycle after a write is accepted -> no register change, ack=0, and block_size_reg = RST_BLKSIZE.
